// File: rtl/asip_pipe_pkg.sv
// Shared types for the vector ASIP pipeline: the EX/MEM payload layout and the
// handshake state encoding used by the EX->MEM stage.
package asip_pipe_pkg;

  localparam int EM_N     = 32;
  localparam int EM_LANES = 4;
  localparam int EM_AW    = 4;
  localparam int EM_CW    = 16;

  // Field order here defines the flat bus packing used inside ex_mem_stage.
  typedef struct packed {
    logic [EM_LANES*EM_N-1:0] RD2;
    logic [EM_LANES*EM_N-1:0] AluResult;
    logic [EM_LANES-1:0]      LaneMask;
    logic                     RF_WE;
    logic                     MemWE;
    logic                     WBSelect;
    logic [EM_AW-1:0]         A3;
  } ex_mem_payload_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } ex_mem_state_t;

  function automatic int payload_width(input int n, input int lanes, input int aw);
    return 2*lanes*n + lanes + 3 + aw;
  endfunction

endpackage

// File: rtl/ex_mem_slot.sv
// One EX/MEM payload register with load enable; synchronous reset clears it so
// outputs read as zero straight after reset.
module ex_mem_slot #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_reg;

  always_ff @(posedge CLK) begin
    if (RST) begin
      q_reg <= '0;
    end else if (load) begin
      q_reg <= d;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline stage: LANES x N payload with valid/ready handshake, a
// one-entry skid buffer, bubble-inserting flush and a saturating stall counter.
module ex_mem_stage
  import asip_pipe_pkg::*;
#(
  parameter int N     = EM_N,
  parameter int LANES = EM_LANES,
  parameter int AW    = EM_AW,
  parameter int CW    = EM_CW
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic               flush_i,
  input  logic [LANES*N-1:0] RD2_i,
  input  logic [LANES*N-1:0] AluResult_i,
  input  logic [LANES-1:0]   LaneMask_i,
  input  logic               RF_WE_i,
  input  logic               MemWE_i,
  input  logic               WBSelect_i,
  input  logic [AW-1:0]      A3_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [LANES*N-1:0] RD2_o,
  output logic [LANES*N-1:0] AluResult_o,
  output logic [LANES-1:0]   LaneMask_o,
  output logic               RF_WE_o,
  output logic               MemWE_o,
  output logic               WBSelect_o,
  output logic [LANES-1:0]   MemWE_lane_o,
  output logic [AW-1:0]      A3_o,
  output logic               hz_we_o,
  output logic [AW-1:0]      hz_A3_o,
  output logic [CW-1:0]      stall_cnt_o
);

  localparam int W = payload_width(N, LANES, AW);

  ex_mem_state_t state_reg, state_next;
  logic          load_h, load_s, h_from_s;
  logic          accept, drain;
  logic [W-1:0]  in_bus, h_d, h_q, s_q;
  logic          rf_we_h, mem_we_h;
  logic [CW-1:0] stall_cnt_reg;

  assign ready_o = (state_reg != TWO);
  assign valid_o = (state_reg != EMPTY);

  // Flush suppresses both sides: the held head is not considered consumed.
  assign accept = valid_i & ready_o & ~flush_i;
  assign drain  = valid_o & ready_i & ~flush_i;

  assign in_bus = {RD2_i, AluResult_i, LaneMask_i, RF_WE_i, MemWE_i, WBSelect_i, A3_i};
  assign h_d    = h_from_s ? s_q : in_bus;

  always_comb begin
    state_next = state_reg;
    load_h     = 1'b0;
    load_s     = 1'b0;
    h_from_s   = 1'b0;
    if (flush_i) begin
      state_next = EMPTY;
    end else begin
      unique case (state_reg)
        EMPTY: begin
          if (accept) begin
            load_h     = 1'b1;
            state_next = ONE;
          end
        end
        ONE: begin
          if (accept && drain) begin
            load_h = 1'b1;
          end else if (accept) begin
            load_s     = 1'b1;
            state_next = TWO;
          end else if (drain) begin
            state_next = EMPTY;
          end
        end
        TWO: begin
          if (drain) begin
            load_h     = 1'b1;
            h_from_s   = 1'b1;
            state_next = ONE;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  ex_mem_slot #(.W(W)) u_head (
    .CLK  (CLK),
    .RST  (RST),
    .load (load_h),
    .d    (h_d),
    .q    (h_q)
  );

  ex_mem_slot #(.W(W)) u_skid (
    .CLK  (CLK),
    .RST  (RST),
    .load (load_s),
    .d    (in_bus),
    .q    (s_q)
  );

  assign {RD2_o, AluResult_o, LaneMask_o, rf_we_h, mem_we_h, WBSelect_o, A3_o} = h_q;

  // Write enables are qualified by valid so a bubble never commits anything.
  assign RF_WE_o = rf_we_h & valid_o;
  assign MemWE_o = mem_we_h & valid_o;
  assign hz_we_o = RF_WE_o;
  assign hz_A3_o = A3_o;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane_we
      assign MemWE_lane_o[gi] = MemWE_o & LaneMask_o[gi];
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt_reg <= '0;
    end else if (valid_o && !ready_i && (stall_cnt_reg != {CW{1'b1}})) begin
      stall_cnt_reg <= stall_cnt_reg + CW'(1);
    end
  end

  assign stall_cnt_o = stall_cnt_reg;

endmodule
